miner_core_compress: RTL
========================

Name: miner_core_compress

Overview:
SHA-256 compression engine that consumes the 64-word message schedule produced by miner_core_msa. It runs the 64 compression rounds at one round per clock and adds the working variables back into the incoming hash state. It then presents the 256-bit intermediate/final digest to the miner control logic. It sits directly downstream of miner_core_msa and shares its clock, reset and w bus format.

Parameters:
ROUNDS, 64, number of compression rounds executed; 64 for SHA-256 compliance, smaller values for debug only (range 1..64).

Ports:
clk  input  1  system clock, rising-edge active
n_rst  input  1  asynchronous active-low reset
compress_en  input  1  start request, sampled only in IDLE
hash_in  input  256 ([0:255])  initial hash state; H0 in bits [0:31] … H7 in bits [224:255]
w  input  64x32 ([0:63][0:31])  message schedule; w[t] is word t, bit 0 is MSB
busy  output  1  high while a compression is in progress (ROUND, FINAL, DONE)
done  output  1  one-cycle pulse, hash_out valid
hash_out  output  256 ([0:255])  resulting hash state, same packing as hash_in

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, round counter=0, working regs a..h=0, latched H regs=0; outputs busy=0, done=0, hash_out=0.
- K[0..63]: standard SHA-256 round constants in an internal combinational ROM.
- All arithmetic is modulo 2^32. Σ0(a)=ROTR2^ROTR13^ROTR22. Σ1(e)=ROTR6^ROTR11^ROTR25. Ch=(e&f)^(~e&g). Maj=(a&b)^(a&c)^(b&c).
- State machine:
  - IDLE: if compress_en=1 at a rising edge, latch hash_in into H0..H7 and into a..h; t=0; go to ROUND. Otherwise stay in IDLE.
  - ROUND: each edge computes T1=h+Σ1(e)+Ch(e,f,g)+K[t]+w[t] and T2=Σ0(a)+Maj(a,b,c). Update h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2, then t=t+1. When t==ROUNDS-1 at the edge, go to FINAL.
  - FINAL: on the next edge, hash_out word i = Hi + {a..h}[i] and go to DONE.
  - DONE: done=1 for this cycle only; on the next edge go to IDLE.
- Latency: compress_en is sampled at edge E0. Rounds occur at edges E1..E64. hash_out is registered at E65, and done is high from E65 to E66. busy is high from E0 to E66, so the core returns to IDLE after E66.
- hash_out holds its value until the next FINAL; it is not cleared on return to IDLE.
- compress_en while busy=1, including in DONE, is ignored with no queuing. The earliest restart is compress_en high at E66, which is sampled in IDLE.
- w and hash_in must stay stable from E0 through E64. hash_in is latched at E0, so later changes to it do not affect the result. w is read live each round.
- Reset asserted mid-operation aborts immediately, with all registers and outputs back to reset values. No done is produced.
- If ROUNDS<64, the counter terminates at ROUNDS-1 and only K[0..ROUNDS-1] and w[0..ROUNDS-1] are used.

Test Plan:
- "abc" single block: hash_in = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, with w expanded from the padded 61626380 00…00 00000018 block. Pulse compress_en. Required: done exactly 65 clocks after the sampling edge, busy high for 66 cycles, and hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: IV plus padded block 80000000 00…00. Required: hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block chaining for "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": run block 1, feed its hash_out back as hash_in for block 2, and restart at E66. Required final hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- compress_en held high throughout the "abc" run. Required: exactly one done pulse with the correct digest. A second compression starts at E66, and its done arrives 65 clocks later.
- n_rst asserted at round 30 of a run. Required: busy=0, done=0 and hash_out=0 immediately, with no done pulse. A fresh "abc" run afterwards yields the correct digest.
- After a completed run, change hash_in and w while in IDLE with compress_en=0. Required: hash_out is unchanged, busy stays 0 and done stays 0.

Source files
------------

// File: rtl/miner_core_compress.sv
// SHA-256 compression core: one round per clock over a 64-word schedule,
// then folds the working variables back into the latched input hash state.
module miner_core_compress #(
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              compress_en,
  input  logic [0:255]      hash_in,
  input  logic [0:63][0:31] w,
  output logic              busy,
  output logic              done,
  output logic [0:255]      hash_out
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_e               state_q, state_d;
  logic [5:0]           t_q, t_d;
  logic [0:7][31:0]     wv_q, wv_d;    // working variables a..h, index 0 = a
  logic [0:7][31:0]     hs_q, hs_d;    // latched H0..H7
  logic [0:7][31:0]     hout_q, hout_d;
  logic [0:7][31:0]     hin_w;
  logic [31:0]          w_t, t1, t2;

  assign hin_w = hash_in;
  assign w_t   = w[t_q];
  assign t1    = wv_q[7] + bsig1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[t_q] + w_t;
  assign t2    = bsig0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      wv_q    <= '0;
      hs_q    <= '0;
      hout_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      wv_q    <= wv_d;
      hs_q    <= hs_d;
      hout_q  <= hout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    wv_d    = wv_q;
    hs_d    = hs_q;
    hout_d  = hout_q;
    case (state_q)
      S_IDLE: begin
        if (compress_en) begin
          hs_d    = hin_w;
          wv_d    = hin_w;
          t_d     = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        wv_d = {t1 + t2, wv_q[0], wv_q[1], wv_q[2], wv_q[3] + t1, wv_q[4], wv_q[5], wv_q[6]};
        t_d  = t_q + 6'd1;
        if (t_q == LAST) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) hout_d[i] = hs_q[i] + wv_q[i];
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign hash_out = hout_q;

endmodule
